// File: rtl/jpc_t1_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jpc_t1_pkg : shared tier-1 pass codes, stripe geometry, contexts |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package jpc_t1_pkg;

    localparam logic [1:0] PASS_SPP = 2'd0;
    localparam logic [1:0] PASS_MRP = 2'd1;
    localparam logic [1:0] PASS_CUP = 2'd2;

    localparam int STRIPE_H = 4;

    localparam int CTX_RUNLEN  = 0;
    localparam int CTX_UNIFORM = 18;
    localparam int CTX_MRP_LO  = 10;
    localparam int CTX_MRP_HI  = 12;
    localparam int CTX_SIGN_LO = 13;
    localparam int CTX_SIGN_HI = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } t1_state_e;

    // Row mask for the bottom stripe; a remainder of 0 means the stripe is full.
    function automatic logic [3:0] tail_mask(input logic [1:0] rem);
        case (rem)
            2'd1:    tail_mask = 4'b0001;
            2'd2:    tail_mask = 4'b0011;
            2'd3:    tail_mask = 4'b0111;
            default: tail_mask = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/t1_scan_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | t1_scan_counter : nested column/stripe position counter          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module t1_scan_counter #(
    parameter int COL_W    = 6,
    parameter int STRIPE_W = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_clr,
    input  logic                i_adv,
    input  logic [COL_W-1:0]    i_last_col,
    input  logic [STRIPE_W-1:0] i_last_stripe,
    output logic [COL_W-1:0]    o_col,
    output logic [STRIPE_W-1:0] o_stripe,
    output logic [COL_W-1:0]    o_col_nxt,
    output logic [STRIPE_W-1:0] o_stripe_nxt,
    output logic                o_wrap
);

    logic [COL_W-1:0]    r_col;
    logic [STRIPE_W-1:0] r_stripe;
    logic                w_col_wrap;

    assign w_col_wrap   = (r_col == i_last_col);
    assign o_wrap       = w_col_wrap && (r_stripe == i_last_stripe);
    assign o_col_nxt    = w_col_wrap ? '0 : r_col + COL_W'(1);
    assign o_stripe_nxt = !w_col_wrap ? r_stripe :
                          (o_wrap ? '0 : r_stripe + STRIPE_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col    <= '0;
            r_stripe <= '0;
        end else if (i_clr) begin
            r_col    <= '0;
            r_stripe <= '0;
        end else if (i_adv) begin
            r_col    <= o_col_nxt;
            r_stripe <= o_stripe_nxt;
        end
    end

    assign o_col    = r_col;
    assign o_stripe = r_stripe;

endmodule
`default_nettype wire

// File: rtl/t1_pass_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | t1_pass_scheduler : EBCOT tier-1 pass/plane/stripe-column sequencer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module t1_pass_scheduler
    import jpc_t1_pkg::*;
#(
    parameter int DIM_W    = 7,
    parameter int COL_W    = 6,
    parameter int STRIPE_W = 4,
    parameter int PLANE_W  = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [DIM_W-1:0]    cb_cols,
    input  logic [DIM_W-1:0]    cb_rows,
    input  logic [PLANE_W-1:0]  num_planes,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_pass,
    output logic [PLANE_W-1:0]  out_plane,
    output logic [STRIPE_W-1:0] out_stripe,
    output logic [COL_W-1:0]    out_col,
    output logic [3:0]          out_rows_mask,
    output logic                out_pass_first,
    output logic                out_pass_last,
    output logic                busy,
    output logic                done
);

    t1_state_e           r_state;
    logic [COL_W-1:0]    r_last_col;
    logic [STRIPE_W-1:0] r_last_stripe;
    logic [3:0]          r_tail_mask;
    logic [1:0]          r_pass;
    logic [PLANE_W-1:0]  r_plane;
    logic [3:0]          r_mask;
    logic                r_first;
    logic                r_last;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;

    logic [COL_W-1:0]    w_in_last_col;
    logic [STRIPE_W-1:0] w_in_last_stripe;
    logic [3:0]          w_in_tail;
    logic                w_zero;
    logic                w_start;
    logic                w_accept;
    logic [COL_W-1:0]    w_col;
    logic [STRIPE_W-1:0] w_stripe;
    logic [COL_W-1:0]    w_col_nxt;
    logic [STRIPE_W-1:0] w_stripe_nxt;
    logic                w_wrap;

    assign w_in_last_col    = COL_W'(cb_cols - DIM_W'(1));
    assign w_in_last_stripe = STRIPE_W'((cb_rows - DIM_W'(1)) / DIM_W'(STRIPE_H));
    assign w_in_tail        = tail_mask(cb_rows[1:0]);
    assign w_zero           = (cb_cols == '0) || (cb_rows == '0) || (num_planes == '0);
    assign w_start          = (r_state == ST_IDLE) && start;
    assign w_accept         = (r_state == ST_RUN) && r_valid && out_ready && !abort;

    t1_scan_counter #(
        .COL_W    (COL_W),
        .STRIPE_W (STRIPE_W)
    ) u_scan (
        .clk           (clk),
        .rstn          (rstn),
        .i_clr         (w_start),
        .i_adv         (w_accept),
        .i_last_col    (r_last_col),
        .i_last_stripe (r_last_stripe),
        .o_col         (w_col),
        .o_stripe      (w_stripe),
        .o_col_nxt     (w_col_nxt),
        .o_stripe_nxt  (w_stripe_nxt),
        .o_wrap        (w_wrap)
    );

    // first/last/mask are registered from the position the counter moves to.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_last_col    <= '0;
            r_last_stripe <= '0;
            r_tail_mask   <= '0;
            r_pass        <= '0;
            r_plane       <= '0;
            r_mask        <= '0;
            r_first       <= 1'b0;
            r_last        <= 1'b0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE && abort) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_last_col    <= w_in_last_col;
                            r_last_stripe <= w_in_last_stripe;
                            r_tail_mask   <= w_in_tail;
                            r_busy        <= 1'b1;
                            if (w_zero) begin
                                r_state <= ST_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                                r_valid <= 1'b1;
                                r_pass  <= PASS_CUP;
                                r_plane <= num_planes - PLANE_W'(1);
                                r_first <= 1'b1;
                                r_last  <= (w_in_last_col == '0) && (w_in_last_stripe == '0);
                                r_mask  <= (w_in_last_stripe == '0) ? w_in_tail : 4'b1111;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_accept) begin
                            if (w_wrap && r_pass == PASS_CUP && r_plane == '0) begin
                                r_state <= ST_FIN;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                if (w_wrap) begin
                                    if (r_pass == PASS_CUP) begin
                                        r_pass  <= PASS_SPP;
                                        r_plane <= r_plane - PLANE_W'(1);
                                    end else begin
                                        r_pass  <= r_pass + 2'd1;
                                    end
                                end
                                r_first <= (w_col_nxt == '0) && (w_stripe_nxt == '0);
                                r_last  <= (w_col_nxt == r_last_col) &&
                                           (w_stripe_nxt == r_last_stripe);
                                r_mask  <= (w_stripe_nxt == r_last_stripe) ? r_tail_mask : 4'b1111;
                            end
                        end
                    end
                    ST_FIN: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_pass       = r_pass;
    assign out_plane      = r_plane;
    assign out_stripe     = w_stripe;
    assign out_col        = w_col;
    assign out_rows_mask  = r_mask;
    assign out_pass_first = r_first;
    assign out_pass_last  = r_last;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_t1_pass_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_t1_pass_scheduler : directed self-checking bench for the scheduler |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_t1_pass_scheduler;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] cb_cols = '0;
    logic [6:0] cb_rows = '0;
    logic [4:0] num_planes = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_pass;
    logic [4:0] out_plane;
    logic [3:0] out_stripe;
    logic [5:0] out_col;
    logic [3:0] out_rows_mask;
    logic       out_pass_first;
    logic       out_pass_last;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    t1_pass_scheduler dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .abort          (abort),
        .cb_cols        (cb_cols),
        .cb_rows        (cb_rows),
        .num_planes     (num_planes),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pass       (out_pass),
        .out_plane      (out_plane),
        .out_stripe     (out_stripe),
        .out_col        (out_col),
        .out_rows_mask  (out_rows_mask),
        .out_pass_first (out_pass_first),
        .out_pass_last  (out_pass_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    logic [22:0] w_obs;
    assign w_obs = {out_pass, out_plane, out_stripe, out_col, out_rows_mask,
                    out_pass_first, out_pass_last};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scan-order reference: beat k of a job, packed like w_obs.
    function automatic logic [22:0] exp_beat(input int cols, input int rows, input int planes, input int k);
        int nstr, per, pidx, pos, stripe, col, plane, pass, rem;
        logic [3:0] mask;
        nstr   = (rows + 3) / 4;
        per    = cols * nstr;
        pidx   = k / per;
        pos    = k % per;
        stripe = pos / cols;
        col    = pos % cols;
        if (pidx == 0) begin
            plane = planes - 1;
            pass  = 2;
        end else begin
            plane = planes - 2 - (pidx - 1) / 3;
            pass  = (pidx - 1) % 3;
        end
        rem  = rows % 4;
        mask = 4'b1111;
        if (stripe == nstr - 1 && rem != 0) mask = 4'((1 << rem) - 1);
        return {2'(pass), 5'(plane), 4'(stripe), 6'(col), mask,
                1'(col == 0 && stripe == 0), 1'(col == cols - 1 && stripe == nstr - 1)};
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic run_job(input int cols, input int rows, input int planes,
                           input bit bp, input int abort_at);
        int total, idx, cyc;
        bit stalled, rdy, aborted;
        logic [22:0] saved;
        total   = cols * ((rows + 3) / 4) * (3 * planes - 2);
        cb_cols = 7'(cols);
        cb_rows = 7'(rows);
        num_planes = 5'(planes);
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        check_eq("start_latency", {busy, out_valid, done}, 3'b110);
        idx = 0; cyc = 0; stalled = 0; aborted = 0; saved = '0;
        while (idx < total && cyc < total * 4 + 20 && !aborted) begin
            if (stalled) check_eq("stall_hold", {out_valid, w_obs}, {1'b1, saved});
            check_eq("beat", {out_valid, w_obs}, {1'b1, exp_beat(cols, rows, planes, idx)});
            check_eq("run_status", {busy, done}, 2'b10);
            rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (idx == abort_at) begin
                rdy = 1'b1;
                abort = 1'b1;
                aborted = 1;
            end
            out_ready = rdy;
            stalled = !rdy;
            saved = w_obs;
            @(posedge clk);
            if (rdy && !aborted) idx++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (aborted) begin
            abort = 1'b0;
            check_eq("abort_clear", {out_valid, busy, done}, 3'b000);
            repeat (3) begin
                @(negedge clk);
                check_eq("abort_no_done", {out_valid, busy, done}, 3'b000);
            end
        end else begin
            check_eq("beat_count", 32'(idx), 32'(total));
            check_eq("done_m1", {out_valid, done, busy}, 3'b011);
            @(negedge clk);
            check_eq("done_m2", {out_valid, done, busy}, 3'b000);
        end
    endtask

    task automatic run_zero(input int cols, input int rows, input int planes);
        cb_cols = 7'(cols);
        cb_rows = 7'(rows);
        num_planes = 5'(planes);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("zero_done", {out_valid, done, busy}, 3'b011);
        @(negedge clk);
        check_eq("zero_idle", {out_valid, done, busy}, 3'b000);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_state", {out_valid, busy, done, w_obs}, 26'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", {out_valid, busy, done, w_obs}, 26'd0);

        run_job(4, 6, 2, 1'b0, -1);
        run_job(1, 4, 1, 1'b0, -1);
        run_job(8, 16, 3, 1'b1, -1);
        run_zero(4, 8, 0);
        run_zero(4, 0, 2);
        run_job(4, 8, 2, 1'b0, 4);
        run_job(1, 4, 1, 1'b0, -1);

        // Mid-job reset, with start held high (and a different config) while busy.
        cb_cols = 7'd2; cb_rows = 7'd4; num_planes = 5'd2;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cb_cols = 7'd5; cb_rows = 7'd9; num_planes = 5'd4;
        for (int k = 0; k < 3; k++) begin
            check_eq("busy_start_ignored", {out_valid, w_obs}, {1'b1, exp_beat(2, 4, 2, k)});
            @(negedge clk);
        end
        #2 rstn = 1'b0;
        #1 check_eq("async_reset", {out_valid, busy, done, w_obs}, 26'd0);
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("post_reset_idle", {out_valid, busy, done, w_obs}, 26'd0);
        run_job(2, 5, 2, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
